oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
- Sprite DMA controller and memory-bus arbiter between the CPU datapath and a 256-byte page copy into PPU OAM.
- A CPU write to the DMA register latches a source page, stalls the CPU via the PC block line, and takes ownership of the memory bus.
- It then performs 256 read/write pairs into OAM and returns the bus to the CPU.
- Sits between cpu_t's memory port and the memory/PPU.

Parameters:
- MEM_ADDR_SIZE, 16, CPU memory address width.
- DMA_REG_ADDR, 16'h4014, address whose CPU write triggers a transfer.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- cpu_mem_addr_i  input  MEM_ADDR_SIZE  CPU bus address.
- cpu_mem_we_i  input  1  CPU bus write enable.
- cpu_mem_wdata_i  input  8  CPU bus write data.
- mem_rdata_i  input  8  memory read data, valid one cycle after the address.
- oam_base_i  input  8  current OAMADDR; first OAM destination index.
- mem_addr_o  output  MEM_ADDR_SIZE  arbitrated memory address.
- mem_we_o  output  1  arbitrated memory write enable.
- mem_wdata_o  output  8  arbitrated memory write data.
- cpu_stall_o  output  1  stalls the CPU (drives PC block).
- oam_we_o  output  1  OAM write strobe.
- oam_addr_o  output  8  OAM write index.
- oam_data_o  output  8  OAM write data.
- busy_o  output  1  transfer in progress (state != IDLE).

Behaviour:
- Reset (synchronous, rst_i=1 at a rising edge):
  - state=IDLE, page_q=0, cnt_q=0, parity_q=0.
  - cpu_stall_o=0, oam_we_o=0, oam_addr_o=0, oam_data_o=0, busy_o=0, mem_we_o=0.
  - mem_addr_o passes through cpu_mem_addr_i.
  - rst_i overrides everything, including a trigger in the same cycle.
- parity_q toggles every clock while out of reset; it is the CPU get/put cycle parity.
- Trigger: in IDLE, a cycle with cpu_mem_we_i=1 and cpu_mem_addr_i==DMA_REG_ADDR.
  - At that edge: page_q<=cpu_mem_wdata_i, cnt_q<=0, state<=HALT.
  - The trigger write itself passes through to memory unchanged.
- States:
  - IDLE: mux passes CPU bus (addr/we/wdata); stall=0. Trigger -> HALT.
  - HALT: stall=1, mem_we_o=0, mem_addr_o=cpu_mem_addr_i. parity_q==1 -> ALIGN, else -> READ.
  - ALIGN: stall=1, bus idle (we=0). -> READ.
  - READ: stall=1, mem_addr_o={page_q,cnt_q}, mem_we_o=0. -> WRITE.
  - WRITE: stall=1, oam_we_o=1, oam_addr_o=oam_base_i+cnt_q (mod 256), oam_data_o=mem_rdata_i.
    - mem_addr_o stays {page_q,cnt_q}.
    - cnt_q==255 -> IDLE; else cnt_q<=cnt_q+1, -> READ.
- oam_we_o is high only in WRITE; oam_addr_o/oam_data_o are combinational in WRITE and 0 elsewhere.
- Latency: stall asserted from the cycle after the trigger for exactly 513 cycles (even parity at HALT) or 514 (odd). cpu_stall_o=0 the cycle after the last WRITE.
- Boundaries:
  - Triggers during a non-IDLE state are ignored; page_q is unchanged.
  - The OAM index wraps mod 256 (oam_base_i=8'hF0 writes F0..FF, then 00..EF).
  - cnt_q 8-bit: ends exactly at 255, no overrun into the next page.
  - page_q=8'hFF reads FF00..FFFF.
  - oam_base_i is sampled combinationally each WRITE; the PPU holds it stable during DMA.
  - Reset mid-transfer: IDLE next cycle, stall released, no further OAM writes, partial OAM contents are left as written.

Decomposition:
- Shared CPU package:
  - dma_state_t enum {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE}.
  - DMA_REG_ADDR constant.
  - ctrl_mux_mem_addr_t gains a DMA_ADDRESS value for cpu_t's address mux.
- Single module, no sub-module; the parity toggle and counter stay inline.

Test Plan:
- Even parity, CPU writes 8'h02 to 16'h4014, memory[0x0200+i]=i^8'h5A, oam_base_i=0 -> stall high 513 cycles; 256 OAM writes, addr i, data i^8'h5A; mem addresses 0200..02FF in order.
- Same trigger issued one cycle later (odd parity at HALT) -> 514 stall cycles; first READ delayed by one ALIGN cycle; data identical.
- oam_base_i=8'hF0, page 8'h03 -> OAM write #0 at F0, #15 at FF, #16 at 00, last at EF; mem addresses 0300..03FF.
- rst_i asserted during the WRITE of cnt=100 -> next cycle busy_o=0, cpu_stall_o=0, no oam_we_o afterward; exactly 100 OAM writes (0..99) precede the reset.
- CPU write to 16'h4015 and read of 16'h4014 -> no stall, busy_o stays 0, bus passes through unchanged; a second 16'h4014 write mid-transfer does not change page_q or extend stall.
- page 8'hFF -> reads FF00..FFFF, ends cleanly at 255, returns to IDLE with cnt_q reset on the next trigger.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared CPU-side definitions for the sprite DMA controller.
// Holds the DMA state encoding, the trigger register address and the
// memory-address mux selector used by the CPU datapath.
package oam_dma_ctrl_pkg;

    // CPU write to this address starts a 256-byte page copy into OAM
    localparam logic [15:0] DMA_REG_ADDR_C = 16'h4014;

    // Last byte index of a page; the copy ends after writing this index
    localparam logic [7:0] DMA_LAST_IDX = 8'hFF;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // Source of the memory address presented to the bus
    typedef enum logic {
        CPU_ADDRESS,
        DMA_ADDRESS
    } ctrl_mux_mem_addr_t;

    // Source byte address for a DMA read: page in the high byte, index low
    function automatic logic [15:0] dma_src_addr(input logic [7:0] page,
                                                 input logic [7:0] idx);
        return {page, idx};
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA controller and CPU/DMA memory-bus arbiter.
// Stalls the CPU 513 cycles (514 on odd get/put parity) after a DMA register write.
// CPU has no backpressure path: while busy it is simply held off the bus via cpu_stall_o.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int                       MEM_ADDR_SIZE = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] DMA_REG_ADDR  = MEM_ADDR_SIZE'(DMA_REG_ADDR_C)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [MEM_ADDR_SIZE-1:0] cpu_mem_addr_i,
    input  logic                     cpu_mem_we_i,
    input  logic [7:0]               cpu_mem_wdata_i,
    input  logic [7:0]               mem_rdata_i,
    input  logic [7:0]               oam_base_i,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr_o,
    output logic                     mem_we_o,
    output logic [7:0]               mem_wdata_o,
    output logic                     cpu_stall_o,
    output logic                     oam_we_o,
    output logic [7:0]               oam_addr_o,
    output logic [7:0]               oam_data_o,
    output logic                     busy_o
);

    dma_state_t          state_q, state_d;
    logic [7:0]          page_q, page_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                parity_q;
    logic                trigger;
    ctrl_mux_mem_addr_t  addr_sel;
    logic                bus_we;
    logic                oam_wr;

    // Only a write to the DMA register while idle starts a copy; later
    // writes to it during a transfer are swallowed by the stalled bus.
    assign trigger = (state_q == DMA_IDLE) && cpu_mem_we_i &&
                     (cpu_mem_addr_i == DMA_REG_ADDR);

    // State, source page, byte counter and get/put parity registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= DMA_IDLE;
            page_q   <= 8'h00;
            cnt_q    <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            cnt_q    <= cnt_d;
            parity_q <= ~parity_q;
        end
    end

    // Next-state: halt, optional alignment cycle, then 256 read/write pairs
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMA_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_mem_wdata_i;
                    cnt_d   = 8'h00;
                    state_d = DMA_HALT;
                end
            end
            DMA_HALT: begin
                // Reads must land on a get cycle; burn one cycle if on a put
                state_d = parity_q ? DMA_ALIGN : DMA_READ;
            end
            DMA_ALIGN: begin
                state_d = DMA_READ;
            end
            DMA_READ: begin
                state_d = DMA_WRITE;
            end
            DMA_WRITE: begin
                if (cnt_q == DMA_LAST_IDX) begin
                    state_d = DMA_IDLE;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = DMA_READ;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    // Outputs: bus arbitration, CPU stall and OAM write strobe per state
    always_comb begin
        addr_sel = CPU_ADDRESS;
        bus_we   = 1'b0;
        oam_wr   = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                bus_we = cpu_mem_we_i;
            end
            DMA_READ: begin
                addr_sel = DMA_ADDRESS;
            end
            DMA_WRITE: begin
                addr_sel = DMA_ADDRESS;
                oam_wr   = 1'b1;
            end
            default: begin
                // HALT/ALIGN: CPU address shown but no write reaches memory
                addr_sel = CPU_ADDRESS;
            end
        endcase

        mem_addr_o  = (addr_sel == DMA_ADDRESS)
                    ? MEM_ADDR_SIZE'(dma_src_addr(page_q, cnt_q))
                    : cpu_mem_addr_i;
        mem_wdata_o = cpu_mem_wdata_i;
        // Reset wins immediately: no bus or OAM write in a reset cycle
        mem_we_o    = bus_we & ~rst_i;
        oam_we_o    = oam_wr & ~rst_i;
        oam_addr_o  = oam_we_o ? (oam_base_i + cnt_q) : 8'h00;
        oam_data_o  = oam_we_o ? mem_rdata_i : 8'h00;
        busy_o      = (state_q != DMA_IDLE);
        cpu_stall_o = busy_o;
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for the sprite DMA controller.
// Memory model returns data one cycle after the address.
// Outputs are sampled 1ns after the falling edge.
module tb_oam_dma_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cpu_mem_addr_i;
    logic        cpu_mem_we_i;
    logic [7:0]  cpu_mem_wdata_i;
    logic [7:0]  mem_rdata_i;
    logic [7:0]  oam_base_i;
    logic [15:0] mem_addr_o;
    logic        mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic        cpu_stall_o;
    logic        oam_we_o;
    logic [7:0]  oam_addr_o;
    logic [7:0]  oam_data_o;
    logic        busy_o;

    int vectors = 0;
    int errors  = 0;
    bit par     = 1'b0;

    oam_dma_ctrl #(.MEM_ADDR_SIZE(16), .DMA_REG_ADDR(16'h4014)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cpu_mem_addr_i (cpu_mem_addr_i),
        .cpu_mem_we_i   (cpu_mem_we_i),
        .cpu_mem_wdata_i(cpu_mem_wdata_i),
        .mem_rdata_i    (mem_rdata_i),
        .oam_base_i     (oam_base_i),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .cpu_stall_o    (cpu_stall_o),
        .oam_we_o       (oam_we_o),
        .oam_addr_o     (oam_addr_o),
        .oam_data_o     (oam_data_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory contents: page 02 holds i^5A at offset i; other pages differ
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    // Synchronous-read memory model
    always @(posedge clk_i) mem_rdata_i <= mem_f(mem_addr_o);

    // Reference get/put parity: cleared by reset, toggles every clock otherwise
    always @(posedge clk_i) par <= rst_i ? 1'b0 : ~par;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to a falling edge where the reference parity equals want
    task automatic wait_par(input bit want);
        for (int g = 0; g < 4 && par != want; g++) @(negedge clk_i);
    endtask

    // Trigger a copy and check the whole transfer; rst_at>=0 resets mid-copy
    task automatic run_dma(input logic [7:0] page, input logic [7:0] base,
                           input bit odd, input int rst_at, input bit retrig);
        int  stall, wr, bad_we, first_wr, post_we;
        bit  done;
        logic [7:0] idx;
        @(negedge clk_i);
        // HALT sees the parity after the trigger edge toggles it
        wait_par(odd ? 1'b0 : 1'b1);
        oam_base_i      = base;
        cpu_mem_addr_i  = 16'h4014;
        cpu_mem_we_i    = 1'b1;
        cpu_mem_wdata_i = page;
        #1;
        chk("trig_pass_we",   mem_we_o, 1);
        chk("trig_pass_addr", mem_addr_o, 16'h4014);
        chk("trig_pass_data", mem_wdata_o, page);
        chk("trig_no_stall",  cpu_stall_o, 0);
        @(negedge clk_i);
        cpu_mem_we_i    = 1'b0;
        cpu_mem_addr_i  = 16'h8000;
        cpu_mem_wdata_i = 8'h00;
        stall = 0; wr = 0; bad_we = 0; first_wr = 0; done = 1'b0;
        for (int c = 0; c < 700 && !done; c++) begin
            if (c > 0) @(negedge clk_i);
            #1;
            if (!cpu_stall_o) begin
                done = 1'b1;
            end else begin
                stall++;
                if (stall == 1) chk("halt_cpu_addr", mem_addr_o, 16'h8000);
                if (mem_we_o) bad_we++;
                if (oam_we_o) begin
                    if (wr == 0) first_wr = stall;
                    if (rst_at >= 0 && wr == rst_at) begin
                        rst_i = 1'b1;
                        #1;
                        chk("rst_gates_oam_we", oam_we_o, 0);
                        chk("rst_writes_before", wr, rst_at);
                        @(negedge clk_i);
                        rst_i = 1'b0;
                        #1;
                        chk("rst_busy", busy_o, 0);
                        chk("rst_stall", cpu_stall_o, 0);
                        post_we = 0;
                        for (int k = 0; k < 8; k++) begin
                            @(negedge clk_i);
                            #1;
                            if (oam_we_o) post_we++;
                        end
                        chk("rst_no_more_oam", post_we, 0);
                        return;
                    end
                    idx = 8'(wr);
                    chk("oam_addr", oam_addr_o, 8'(base + idx));
                    chk("oam_data", oam_data_o, mem_f({page, idx}));
                    chk("src_addr", mem_addr_o, {page, idx});
                    wr++;
                end
                if (retrig && stall == 50) begin
                    cpu_mem_addr_i  = 16'h4014;
                    cpu_mem_we_i    = 1'b1;
                    cpu_mem_wdata_i = 8'h77;
                end else if (retrig && stall == 51) begin
                    cpu_mem_addr_i  = 16'h8000;
                    cpu_mem_we_i    = 1'b0;
                    cpu_mem_wdata_i = 8'h00;
                end
            end
        end
        chk("stall_released", done, 1);
        chk("stall_cycles", stall, odd ? 514 : 513);
        chk("oam_write_count", wr, 256);
        chk("first_write_pos", first_wr, odd ? 4 : 3);
        chk("no_mem_we_in_dma", bad_we, 0);
        chk("idle_after", busy_o, 0);
    endtask

    initial begin
        // Reset with a simultaneous trigger: reset must win
        rst_i           = 1'b1;
        cpu_mem_addr_i  = 16'h4014;
        cpu_mem_we_i    = 1'b1;
        cpu_mem_wdata_i = 8'h55;
        oam_base_i      = 8'h00;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_busy0",     busy_o, 0);
        chk("rst_stall0",    cpu_stall_o, 0);
        chk("rst_oam_we0",   oam_we_o, 0);
        chk("rst_oam_addr0", oam_addr_o, 0);
        chk("rst_oam_data0", oam_data_o, 0);
        chk("rst_mem_we0",   mem_we_o, 0);
        chk("rst_addr_pass", mem_addr_o, 16'h4014);
        rst_i        = 1'b0;
        cpu_mem_we_i = 1'b0;
        @(negedge clk_i);
        #1;
        chk("rst_trig_ignored", busy_o, 0);

        // Write to a neighbouring register and a read of the DMA register
        cpu_mem_addr_i  = 16'h4015;
        cpu_mem_we_i    = 1'b1;
        cpu_mem_wdata_i = 8'hA5;
        #1;
        chk("pass_4015_we",   mem_we_o, 1);
        chk("pass_4015_addr", mem_addr_o, 16'h4015);
        chk("pass_4015_data", mem_wdata_o, 8'hA5);
        @(negedge clk_i);
        cpu_mem_addr_i = 16'h4014;
        cpu_mem_we_i   = 1'b0;
        #1;
        chk("read_4014_busy", busy_o, 0);
        chk("read_4014_we",   mem_we_o, 0);
        @(negedge clk_i);
        #1;
        chk("after_4015_busy",  busy_o, 0);
        chk("after_4015_stall", cpu_stall_o, 0);

        run_dma(8'h02, 8'h00, 1'b0, -1, 1'b0);   // even parity
        run_dma(8'h02, 8'h00, 1'b1, -1, 1'b0);   // odd parity, ALIGN cycle
        run_dma(8'h03, 8'hF0, 1'b0, -1, 1'b1);   // OAM index wrap + ignored retrigger
        run_dma(8'h02, 8'h00, 1'b0, 100, 1'b0);  // reset during WRITE of cnt=100
        run_dma(8'hFF, 8'h00, 1'b1, -1, 1'b0);   // last page
        run_dma(8'h04, 8'h10, 1'b0, -1, 1'b0);   // counter restarts at 0

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Hard ceiling so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
